// File: rtl/p_i_cache_ctrl_nway.sv
// p_i_cache_ctrl_nway: control FSM for an N-way set-associative instruction
// cache with tree-PLRU replacement, blocking line fill and a set-by-set
// invalidate-all flush. All outputs are combinational from state and inputs.
module p_i_cache_ctrl_nway #(
   parameter int NUM_WAYS = 4,
   parameter int NUM_SETS = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_read,
   output logic                        mem_resp,
   output logic                        pmem_read,
   input  logic                        pmem_resp,
   input  logic                        hit_in,
   input  logic [NUM_WAYS-1:0]         hit_way,
   input  logic [NUM_WAYS-1:0]         valid_out,
   input  logic [NUM_WAYS-2:0]         plru_in,
   input  logic                        flush,
   output logic [NUM_WAYS-1:0]         valid_load,
   output logic                        valid_datain,
   output logic [NUM_WAYS-1:0]         tag_load,
   output logic [NUM_WAYS-1:0]         data_fill_we,
   output logic                        plru_load,
   output logic [NUM_WAYS-2:0]         plru_datain,
   output logic                        load_pipe_reg,
   output logic [1:0]                  addr_sel,
   output logic [$clog2(NUM_SETS)-1:0] flush_idx,
   output logic                        flush_busy
);

   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam int IDX_W = $clog2(NUM_SETS);

   localparam logic [1:0] S_LOOKUP = 2'd0;
   localparam logic [1:0] S_MISS   = 2'd1;
   localparam logic [1:0] S_FLUSH  = 2'd2;

   localparam logic [1:0] ADDR_CUR   = 2'd0;
   localparam logic [1:0] ADDR_PREV  = 2'd1;
   localparam logic [1:0] ADDR_FLUSH = 2'd2;

   logic [1:0]          state, state_next;
   logic                pending, pending_next;
   logic [IDX_W-1:0]    flush_idx_next;
   logic [WAY_W-1:0]    hit_idx;
   logic [WAY_W-1:0]    victim;
   logic [NUM_WAYS-1:0] victim_oh;

   // Tree layout: node 0 is the root, node n has children 2n+1 / 2n+2, and a
   // bit of 1 means the victim lies in the right subtree. Touching way w makes
   // every node on its path point away from w.
   function automatic logic [NUM_WAYS-2:0] plru_update(input logic [NUM_WAYS-2:0] p,
                                                       input logic [WAY_W-1:0]    w);
      logic [NUM_WAYS-2:0] r;
      int node;
      r = p;
      for (int l = 0; l < WAY_W; l++) begin
         node = (1 << l) - 1 + int'(w >> (WAY_W - l));
         r[node] = ~w[WAY_W-1-l];
      end
      return r;
   endfunction

   // Follow the tree bits from the root down to a leaf.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] p);
      int node;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         node = 2 * node + 1 + int'(p[node]);
      end
      return WAY_W'(node - (NUM_WAYS - 1));
   endfunction

   // One-hot hit vector to way index.
   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (hit_way[i]) hit_idx = WAY_W'(i);
      end
   end

   // Victim: lowest invalid way, otherwise the PLRU tree walk.
   always_comb begin
      victim = plru_victim(plru_in);
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!valid_out[i]) victim = WAY_W'(i);
      end
      victim_oh = {{(NUM_WAYS-1){1'b0}}, 1'b1} << victim;
   end

   // Next-state and output decode; reset forces the idle output pattern.
   always_comb begin
      // NOTE: every output and next-state value gets a default first, so no
      // path through the case below can leave one unassigned and infer a latch.
      state_next     = state;
      pending_next   = pending;
      flush_idx_next = flush_idx;
      mem_resp       = 1'b0;
      pmem_read      = 1'b0;
      valid_load     = '0;
      valid_datain   = 1'b0;
      tag_load       = '0;
      data_fill_we   = '0;
      plru_load      = 1'b0;
      plru_datain    = '0;
      load_pipe_reg  = 1'b1;
      addr_sel       = ADDR_CUR;
      flush_busy     = 1'b0;

      if (!rst) begin
         case (state)
            S_LOOKUP: begin
               if (mem_read && hit_in) begin
                  mem_resp    = 1'b1;
                  plru_load   = 1'b1;
                  plru_datain = plru_update(plru_in, hit_idx);
               end else if (mem_read) begin
                  // Freeze the pipeline on the missing address.
                  load_pipe_reg = 1'b0;
                  addr_sel      = ADDR_PREV;
                  state_next    = S_MISS;
               end
               // A flush wins over a miss; the miss is retried afterwards.
               if (flush) state_next = S_FLUSH;
            end

            S_MISS: begin
               pmem_read     = 1'b1;
               addr_sel      = ADDR_PREV;
               load_pipe_reg = 1'b0;
               if (pmem_resp) begin
                  tag_load     = victim_oh;
                  valid_load   = victim_oh;
                  data_fill_we = victim_oh;
                  valid_datain = 1'b1;
                  plru_load    = 1'b1;
                  plru_datain  = plru_update(plru_in, victim);
                  pending_next = 1'b0;
                  state_next   = (pending || flush) ? S_FLUSH : S_LOOKUP;
               end else if (flush) begin
                  pending_next = 1'b1;
               end
            end

            S_FLUSH: begin
               flush_busy    = 1'b1;
               addr_sel      = ADDR_FLUSH;
               valid_load    = '1;
               valid_datain  = 1'b0;
               plru_load     = 1'b1;
               plru_datain   = '0;
               load_pipe_reg = 1'b0;
               pending_next  = 1'b0;
               if (flush_idx == IDX_W'(NUM_SETS - 1)) begin
                  flush_idx_next = '0;
                  state_next     = S_LOOKUP;
               end else begin
                  flush_idx_next = flush_idx + 1'b1;
               end
            end

            default: state_next = S_LOOKUP;
         endcase
      end
   end

   // State, flush counter and deferred-flush flag.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state     <= S_LOOKUP;
         pending   <= 1'b0;
         flush_idx <= '0;
      end else begin
         state     <= state_next;
         pending   <= pending_next;
         flush_idx <= flush_idx_next;
      end
   end

endmodule

// File: tb/tb_p_i_cache_ctrl_nway.sv
// tb_p_i_cache_ctrl_nway: scoreboard bench for the I-cache control FSM.
// Expected output vectors are queued as stimulus is applied and compared once
// the combinational outputs settle, away from the rising edge.
module tb_p_i_cache_ctrl_nway;

   logic       clk;
   logic       rst;
   logic       mem_read, pmem_resp, hit_in, flush;
   logic [3:0] hit_way, valid_out;
   logic [2:0] plru_in;
   logic       mem_resp, pmem_read, valid_datain, plru_load, load_pipe_reg, flush_busy;
   logic [3:0] valid_load, tag_load, data_fill_we;
   logic [2:0] plru_datain;
   logic [1:0] addr_sel;
   logic [2:0] flush_idx;

   // Second instance for the 8-way configuration.
   logic       mr8, pr8, hit8, fl8;
   logic [7:0] hw8, vo8;
   logic [6:0] pl8;
   logic       mem_resp8, pmem_read8, valid_datain8, plru_load8, lpr8, busy8;
   logic [7:0] valid_load8, tag_load8, data_fill_we8;
   logic [6:0] plru_datain8;
   logic [1:0] addr_sel8;
   logic [2:0] flush_idx8;

   typedef struct {
      logic       mem_resp;
      logic       pmem_read;
      logic [3:0] valid_load;
      logic       valid_datain;
      logic [3:0] tag_load;
      logic [3:0] data_fill_we;
      logic       plru_load;
      logic [2:0] plru_datain;
      logic       load_pipe_reg;
      logic [1:0] addr_sel;
      logic [2:0] flush_idx;
      logic       flush_busy;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   p_i_cache_ctrl_nway #(.NUM_WAYS(4), .NUM_SETS(8)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_resp(pmem_resp), .hit_in(hit_in),
      .hit_way(hit_way), .valid_out(valid_out), .plru_in(plru_in), .flush(flush),
      .valid_load(valid_load), .valid_datain(valid_datain), .tag_load(tag_load),
      .data_fill_we(data_fill_we), .plru_load(plru_load), .plru_datain(plru_datain),
      .load_pipe_reg(load_pipe_reg), .addr_sel(addr_sel), .flush_idx(flush_idx),
      .flush_busy(flush_busy)
   );

   p_i_cache_ctrl_nway #(.NUM_WAYS(8), .NUM_SETS(8)) dut8 (
      .clk(clk), .rst(rst), .mem_read(mr8), .mem_resp(mem_resp8),
      .pmem_read(pmem_read8), .pmem_resp(pr8), .hit_in(hit8),
      .hit_way(hw8), .valid_out(vo8), .plru_in(pl8), .flush(fl8),
      .valid_load(valid_load8), .valid_datain(valid_datain8), .tag_load(tag_load8),
      .data_fill_we(data_fill_we8), .plru_load(plru_load8), .plru_datain(plru_datain8),
      .load_pipe_reg(lpr8), .addr_sel(addr_sel8), .flush_idx(flush_idx8),
      .flush_busy(busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t exp_idle();
      exp_t e;
      e.mem_resp      = 1'b0;
      e.pmem_read     = 1'b0;
      e.valid_load    = 4'b0000;
      e.valid_datain  = 1'b0;
      e.tag_load      = 4'b0000;
      e.data_fill_we  = 4'b0000;
      e.plru_load     = 1'b0;
      e.plru_datain   = 3'b000;
      e.load_pipe_reg = 1'b1;
      e.addr_sel      = 2'd0;
      e.flush_idx     = 3'd0;
      e.flush_busy    = 1'b0;
      return e;
   endfunction

   function automatic exp_t exp_miss();
      exp_t e;
      e = exp_idle();
      e.pmem_read     = 1'b1;
      e.addr_sel      = 2'd1;
      e.load_pipe_reg = 1'b0;
      return e;
   endfunction

   function automatic exp_t exp_fill(input logic [3:0] way_oh, input logic [2:0] plru);
      exp_t e;
      e = exp_miss();
      e.tag_load     = way_oh;
      e.valid_load   = way_oh;
      e.data_fill_we = way_oh;
      e.valid_datain = 1'b1;
      e.plru_load    = 1'b1;
      e.plru_datain  = plru;
      return e;
   endfunction

   function automatic exp_t exp_hit(input logic [2:0] plru);
      exp_t e;
      e = exp_idle();
      e.mem_resp    = 1'b1;
      e.plru_load   = 1'b1;
      e.plru_datain = plru;
      return e;
   endfunction

   function automatic exp_t exp_miss_req();
      exp_t e;
      e = exp_idle();
      e.load_pipe_reg = 1'b0;
      e.addr_sel      = 2'd1;
      return e;
   endfunction

   task automatic drive(input logic mr, input logic hit, input logic [3:0] hw,
                        input logic [3:0] vo, input logic [2:0] pl,
                        input logic fl, input logic pr);
      mem_read  = mr;
      hit_in    = hit;
      hit_way   = hw;
      valid_out = vo;
      plru_in   = pl;
      flush     = fl;
      pmem_resp = pr;
   endtask

   // Queue the expectation, let outputs settle, compare, advance one cycle.
   task automatic step(input string tag, input exp_t e);
      exp_t g;
      sb.push_back(e);
      #1;
      g = sb.pop_front();
      check({tag, ".mem_resp"},      mem_resp,      g.mem_resp);
      check({tag, ".pmem_read"},     pmem_read,     g.pmem_read);
      check({tag, ".valid_load"},    valid_load,    g.valid_load);
      check({tag, ".valid_datain"},  valid_datain,  g.valid_datain);
      check({tag, ".tag_load"},      tag_load,      g.tag_load);
      check({tag, ".data_fill_we"},  data_fill_we,  g.data_fill_we);
      check({tag, ".plru_load"},     plru_load,     g.plru_load);
      check({tag, ".plru_datain"},   plru_datain,   g.plru_datain);
      check({tag, ".load_pipe_reg"}, load_pipe_reg, g.load_pipe_reg);
      check({tag, ".addr_sel"},      addr_sel,      g.addr_sel);
      check({tag, ".flush_idx"},     flush_idx,     g.flush_idx);
      check({tag, ".flush_busy"},    flush_busy,    g.flush_busy);
      @(negedge clk);
   endtask

   // Eight invalidation cycles; a stray flush and a hit inside are ignored.
   task automatic run_flush(input string tag);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         drive(i == 3, i == 3, 4'b0001, 4'b1111, 3'b000, i == 5, 1'b0);
         e = exp_idle();
         e.flush_busy    = 1'b1;
         e.addr_sel      = 2'd2;
         e.valid_load    = 4'b1111;
         e.plru_load     = 1'b1;
         e.load_pipe_reg = 1'b0;
         e.flush_idx     = 3'(i);
         step($sformatf("%s_cyc%0d", tag, i), e);
      end
      drive(0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
      step({tag, "_done"}, exp_idle());
   endtask

   initial begin
      mr8 = 0; pr8 = 0; hit8 = 0; fl8 = 0; hw8 = '0; vo8 = '0; pl8 = '0;
      rst = 1'b1;
      // Reset gates a would-be hit.
      drive(1, 1, 4'b0100, 4'b0000, 3'b000, 0, 0);
      step("reset", exp_idle());
      rst = 1'b0;

      // Hit path: way 2 from 000 -> 100.
      drive(1, 1, 4'b0100, 4'b0000, 3'b000, 0, 0);
      step("hit", exp_hit(3'b100));
      drive(0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
      step("hit_idle", exp_idle());

      // Cold miss: lowest invalid way 2.
      drive(1, 0, 4'b0000, 4'b0011, 3'b000, 0, 0);
      step("cold_req", exp_miss_req());
      for (int i = 0; i < 3; i++) step($sformatf("cold_wait%0d", i), exp_miss());
      drive(1, 0, 4'b0000, 4'b0011, 3'b000, 0, 1);
      step("cold_fill", exp_fill(4'b0100, 3'b100));
      drive(1, 1, 4'b0100, 4'b0111, 3'b100, 0, 0);
      step("cold_retry", exp_hit(3'b100));

      // Full set: tree 101 points at way 3, update clears its path.
      drive(1, 0, 4'b0000, 4'b1111, 3'b101, 0, 0);
      step("plru_req", exp_miss_req());
      drive(1, 0, 4'b0000, 4'b1111, 3'b101, 0, 1);
      step("plru_fill", exp_fill(4'b1000, 3'b000));
      drive(0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
      step("plru_idle", exp_idle());

      // Flush arriving mid-miss is deferred until the fill completes.
      drive(1, 0, 4'b0000, 4'b0001, 3'b000, 0, 0);
      step("mflush_req", exp_miss_req());
      drive(1, 0, 4'b0000, 4'b0001, 3'b000, 1, 0);
      step("mflush_pulse", exp_miss());
      drive(1, 0, 4'b0000, 4'b0001, 3'b000, 0, 0);
      step("mflush_wait", exp_miss());
      drive(1, 0, 4'b0000, 4'b0001, 3'b000, 0, 1);
      step("mflush_fill", exp_fill(4'b0010, 3'b001));
      run_flush("mflush");

      // Hit with same-cycle flush still responds: way 0 -> 011.
      drive(1, 1, 4'b0001, 4'b1111, 3'b000, 1, 0);
      step("hflush_hit", exp_hit(3'b011));
      run_flush("hflush");

      // Miss with same-cycle flush: flush first, miss retried after.
      drive(1, 0, 4'b0000, 4'b0000, 3'b000, 1, 0);
      step("xflush_req", exp_miss_req());
      run_flush("xflush");
      drive(1, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);
      step("xflush_retry", exp_miss_req());
      step("xflush_miss", exp_miss());

      // Reset while pmem_read is high drops it before the next edge.
      rst = 1'b1;
      drive(1, 1, 4'b0001, 4'b0000, 3'b000, 0, 0);
      step("rst_mid_miss", exp_idle());
      rst = 1'b0;
      drive(1, 1, 4'b0001, 4'b0000, 3'b000, 0, 0);
      step("post_rst_hit", exp_hit(3'b011));
      drive(0, 0, 4'b0000, 4'b0000, 3'b000, 0, 0);

      // 8-way: all valid, tree all-zero -> way 0, nodes 0,1,3 set.
      mr8 = 1'b1; vo8 = 8'hFF; pl8 = 7'b0000000;
      #1;
      check("w8_req.addr_sel", addr_sel8, 2'd1);
      @(negedge clk);
      pr8 = 1'b1;
      #1;
      check("w8_fill.data_fill_we", data_fill_we8, 8'h01);
      check("w8_fill.tag_load",     tag_load8,     8'h01);
      check("w8_fill.plru_datain",  plru_datain8,  7'b0001011);
      check("w8_fill.valid_datain", valid_datain8, 1'b1);
      @(negedge clk);
      mr8 = 1'b0; pr8 = 1'b0;
      #1;
      check("w8_after.pmem_read", pmem_read8, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
